// File: rtl/seg_execute_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide sequencer.
package seg_execute_muldiv_pkg;

    localparam int NB_DATA_DEF = 32;
    localparam int NB_FUNC_DEF = 6;
    localparam int NB_CNT_DEF  = 6;

    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_e;

endpackage

// File: rtl/seg_execute_muldiv_datapath.sv
// Product/remainder shift register, shared add/subtract and sign-fix negation
// for the iterative multiply/divide; sequenced by seg_execute_muldiv_ctrl.
module seg_execute_muldiv_datapath #(
    parameter int NB_DATA = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_load,
    input  logic               i_load_signed,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic               i_step_mul,
    input  logic               i_step_div,
    input  logic               i_neg_full,
    input  logic               i_neg_hi,
    input  logic               i_neg_lo,
    output logic [NB_DATA-1:0] o_res_hi,
    output logic [NB_DATA-1:0] o_res_lo
);

    localparam int NB_ACC = 2 * NB_DATA;

    logic [NB_ACC-1:0]  acc_q, acc_d;
    logic [NB_DATA-1:0] opb_q, opb_d;
    logic [NB_DATA-1:0] mag_a, mag_b;
    logic [NB_DATA+1:0] add_x, add_y, add_sum;
    logic [NB_ACC-1:0]  acc_neg;

    always_comb begin
        mag_a = (i_load_signed && i_data_a[NB_DATA-1]) ? (~i_data_a + NB_DATA'(1)) : i_data_a;
        mag_b = (i_load_signed && i_data_b[NB_DATA-1]) ? (~i_data_b + NB_DATA'(1)) : i_data_b;
    end

    // Multiply adds the multiplicand to the upper half; divide subtracts the
    // divisor from the left-shifted remainder (N+1 bits) and reads the borrow.
    always_comb begin
        add_x   = i_step_div ? {1'b0, acc_q[NB_ACC-1:NB_DATA-1]} : {2'b00, acc_q[NB_ACC-1:NB_DATA]};
        add_y   = {2'b00, opb_q};
        add_sum = add_x + (i_step_div ? ~add_y : add_y) + {{(NB_DATA+1){1'b0}}, i_step_div};
    end

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_d = acc_q;
        opb_d = opb_q;
        if (i_load) begin
            acc_d = {{NB_DATA{1'b0}}, mag_a};
            opb_d = mag_b;
        end else if (i_step_mul) begin
            if (acc_q[0]) acc_d = {add_sum[NB_DATA:0], acc_q[NB_DATA-1:1]};
            else          acc_d = {1'b0, acc_q[NB_ACC-1:1]};
        end else if (i_step_div) begin
            if (!add_sum[NB_DATA+1]) acc_d = {add_sum[NB_DATA-1:0], acc_q[NB_DATA-2:0], 1'b1};
            else                     acc_d = {acc_q[NB_ACC-2:0], 1'b0};
        end
    end

    always_comb begin
        acc_neg  = ~acc_q + NB_ACC'(1);
        o_res_hi = acc_q[NB_ACC-1:NB_DATA];
        o_res_lo = acc_q[NB_DATA-1:0];
        if (i_neg_full) begin
            o_res_hi = acc_neg[NB_ACC-1:NB_DATA];
            o_res_lo = acc_neg[NB_DATA-1:0];
        end else begin
            if (i_neg_hi) o_res_hi = ~acc_q[NB_ACC-1:NB_DATA] + NB_DATA'(1);
            if (i_neg_lo) o_res_lo = ~acc_q[NB_DATA-1:0] + NB_DATA'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc_q <= '0;
            opb_q <= '0;
        end else begin
            acc_q <= acc_d;
            opb_q <= opb_d;
        end
    end

endmodule

// File: rtl/seg_execute_muldiv_ctrl.sv
// Execute-stage sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO; owns HI/LO and
// stalls the pipeline while the iterative datapath runs.
module seg_execute_muldiv_ctrl
    import seg_execute_muldiv_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_FUNC = NB_FUNC_DEF,
    parameter int NB_CNT  = NB_CNT_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [NB_FUNC-1:0] i_funct,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    output logic               o_stall,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_div_by_zero,
    output logic [NB_DATA-1:0] o_hi,
    output logic [NB_DATA-1:0] o_lo
);

    state_e             state_q, state_d;
    logic [NB_CNT-1:0]  cnt_q, cnt_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_div_q, is_div_d;
    logic               dbz_q, dbz_d;
    logic [NB_DATA-1:0] hi_q, hi_d;
    logic [NB_DATA-1:0] lo_q, lo_d;

    logic is_mul_op, is_div_op, is_signed_op, b_zero, start, last_iter;
    logic load, step_mul, step_div, neg_full, neg_hi, neg_lo;
    logic [NB_DATA-1:0] res_hi, res_lo;

    always_comb begin
        is_mul_op    = (i_funct == NB_FUNC'(FUNCT_MULT)) || (i_funct == NB_FUNC'(FUNCT_MULTU));
        is_div_op    = (i_funct == NB_FUNC'(FUNCT_DIV))  || (i_funct == NB_FUNC'(FUNCT_DIVU));
        is_signed_op = (i_funct == NB_FUNC'(FUNCT_MULT)) || (i_funct == NB_FUNC'(FUNCT_DIV));
        b_zero       = (i_data_b == '0);
        start        = i_valid && (state_q == ST_IDLE) && (is_mul_op || is_div_op);
        last_iter    = (cnt_q == NB_CNT'(NB_DATA - 1));
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        is_div_d = is_div_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        load     = 1'b0;
        step_mul = 1'b0;
        step_div = 1'b0;
        neg_full = 1'b0;
        neg_hi   = 1'b0;
        neg_lo   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    load     = 1'b1;
                    sign_a_d = is_signed_op && i_data_a[NB_DATA-1];
                    sign_b_d = is_signed_op && i_data_b[NB_DATA-1];
                    is_div_d = is_div_op;
                    dbz_d    = is_div_op && b_zero;
                    cnt_d    = '0;
                    if (!is_div_op)  state_d = ST_MUL;
                    else if (b_zero) state_d = ST_DONE;
                    else             state_d = ST_DIV;
                end else if (i_valid && (i_funct == NB_FUNC'(FUNCT_MTHI))) begin
                    hi_d = i_data_a;
                end else if (i_valid && (i_funct == NB_FUNC'(FUNCT_MTLO))) begin
                    lo_d = i_data_a;
                end
            end
            ST_MUL, ST_DIV: begin
                step_mul = (state_q == ST_MUL);
                step_div = (state_q == ST_DIV);
                cnt_d    = last_iter ? '0 : cnt_q + NB_CNT'(1);
                if (last_iter) state_d = ST_FIX;
            end
            ST_FIX: begin
                // Product sign follows a^b; remainder takes the dividend's sign.
                neg_full = !is_div_q && (sign_a_q ^ sign_b_q);
                neg_lo   = is_div_q && (sign_a_q ^ sign_b_q);
                neg_hi   = is_div_q && sign_a_q;
                hi_d     = res_hi;
                lo_d     = res_lo;
                state_d  = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_div_q <= is_div_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    seg_execute_muldiv_datapath #(
        .NB_DATA(NB_DATA)
    ) u_datapath (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_load       (load),
        .i_load_signed(is_signed_op),
        .i_data_a     (i_data_a),
        .i_data_b     (i_data_b),
        .i_step_mul   (step_mul),
        .i_step_div   (step_div),
        .i_neg_full   (neg_full),
        .i_neg_hi     (neg_hi),
        .i_neg_lo     (neg_lo),
        .o_res_hi     (res_hi),
        .o_res_lo     (res_lo)
    );

    always_comb begin
        o_stall       = start || (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
        o_busy        = (state_q != ST_IDLE);
        o_done        = (state_q == ST_DONE);
        o_div_by_zero = (state_q == ST_DONE) && dbz_q;
        o_hi          = hi_q;
        o_lo          = lo_q;
    end

endmodule

// File: doc/seg_execute_muldiv_ctrl.md
Name: seg_execute_muldiv_ctrl

Overview:
Execute-stage sequencer for the MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO instructions, which the single-cycle ALU cannot handle.
- Owns the HI/LO architectural registers.
- Runs an iterative shift-add multiply or restoring divide over NB_DATA cycles.
- Holds o_stall high so hazard logic freezes IF/ID/EX until the result is committed.
- Sits beside seg_execute_alu and shares the same ID/EX operands and funct field.

Parameters:
NB_DATA, 32, operand and HI/LO width.
NB_FUNC, 6, funct field width.
NB_CNT, 6, iteration counter width; must satisfy 2^NB_CNT > NB_DATA.

Ports:
i_clock  in  1  system clock, rising edge.
i_reset  in  1  synchronous, active-high reset.
i_valid  in  1  EX stage holds a valid R-type instruction this cycle.
i_funct  in  NB_FUNC  funct field of the EX instruction.
i_data_a  in  NB_DATA  rs operand (forwarded).
i_data_b  in  NB_DATA  rt operand (forwarded).
o_stall  out  1  freeze the pipeline at or before EX.
o_busy  out  1  registered; FSM not in IDLE.
o_done  out  1  one-cycle pulse; HI/LO just committed by a MULT/DIV.
o_div_by_zero  out  1  one-cycle pulse; DIV/DIVU with rt==0.
o_hi  out  NB_DATA  HI register; MFHI reads it.
o_lo  out  NB_DATA  LO register; MFLO reads it.

Behaviour:
Reset (synchronous, i_reset high at a rising edge):
- state=IDLE; HI=LO=0; counter=0.
- o_busy, o_done, o_div_by_zero = 0; o_stall = 0 on the following cycle.
- Reset mid-operation aborts the computation, discards partial results and zeroes HI/LO.

Decode: start = i_valid && state==IDLE && funct ∈ {MULT 011000, MULTU 011001, DIV 011010, DIVU 011011}. Other funct values are ignored.

MTHI (010001) / MTLO (010011):
- Taken only in IDLE with i_valid high.
- HI or LO <= i_data_a at the clock edge; no stall.

States: IDLE, MUL, DIV, FIX, DONE.
- IDLE: on start, latch the operands.
  - Signed ops: latch magnitudes and record sign_a and sign_b.
  - Unsigned ops: sign_a = sign_b = 0.
  - Next state: MUL, or DIV if rt≠0, or DONE directly if DIV/DIVU with rt==0.
- MUL:
  - One shift-add step per cycle on a 2*NB_DATA product register.
  - Counter runs 0..NB_DATA-1, then FIX.
- DIV:
  - One restoring step per cycle: shift the remainder left, trial-subtract the divisor, set the quotient bit.
  - NB_DATA cycles, then FIX.
- FIX: sign correction, two's complement.
  - Signed MULT: if sign_a^sign_b, negate the full 2*NB_DATA product.
  - Signed DIV: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Write HI/LO at the end of FIX.
    - MULT: HI = product[2N-1:N], LO = product[N-1:0].
    - DIV: LO = quotient, HI = remainder.
- DONE: lasts one cycle.
  - o_done=1.
  - o_stall=0, so the instruction leaves EX.
  - i_valid is ignored here because it is the same instruction.
  - Next state: IDLE.

o_stall (combinational) = start || state ∈ {MUL, DIV, FIX}.
- Stall length: NB_DATA+2 cycles for MULT/DIV (accept cycle, NB_DATA iterations, FIX).
- Stall length: 1 cycle for divide-by-zero.
- HI/LO become valid in the DONE cycle, so an MFHI in the next EX cycle reads the new value.

Divide by zero:
- HI/LO unchanged.
- o_div_by_zero pulses in the DONE cycle together with o_done.

Overflow cases:
- Signed -2^(N-1) / -1 gives LO = 0x80000000, HI = 0; magnitude arithmetic wraps naturally.
- No exception is raised.

Simultaneous events:
- i_reset has priority over everything.
- A start that arrives while busy is impossible because the pipeline is stalled.
- MTHI/MTLO arriving in DONE is ignored and is not re-executed; hazard logic must re-present it.

Decomposition:
- Shared package contains:
  - funct constants FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO.
  - FSM state encoding.
  - NB_DATA default.
- One natural sub-module, seg_execute_muldiv_datapath:
  - Contains the product/remainder shift registers, the NB_DATA+1-bit adder/subtractor, and negation.
  - Driven by step/load/fix controls from this FSM.

Test Plan (NB_DATA=32):
- MULT a=7, b=0xFFFFFFFD (-3) -> o_stall high for exactly 34 cycles; DONE cycle HI=0xFFFFFFFF, LO=0xFFFFFFEB; o_done pulses once.
- MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 -> LO=14, HI=2.
- DIVU a=100, b=0 with HI/LO preloaded to 0x11/0x22 via MTHI/MTLO -> 1 stall cycle; o_div_by_zero and o_done pulse together; HI=0x11, LO=0x22.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0, no stall anomaly; MTLO 0x5 in IDLE -> LO=5 next cycle with o_stall=0.
- Start MULT 3*5, assert i_reset on the 10th busy cycle -> next cycle state IDLE, HI=LO=0, o_stall=o_busy=0, no o_done; a fresh MULT afterwards gives LO=15.
